// File: rtl/gol_pkg.sv
// Shared neighbourhood definitions: neighbour index enum, dx/dy offset tables, mode constants.
package gol_pkg;

  localparam int unsigned NEIGHBOURS_CNT = 8;

  typedef enum logic [2:0] {
    NBR_NW = 3'd0,
    NBR_N  = 3'd1,
    NBR_NE = 3'd2,
    NBR_W  = 3'd3,
    NBR_E  = 3'd4,
    NBR_SW = 3'd5,
    NBR_S  = 3'd6,
    NBR_SE = 3'd7
  } nbr_idx_e;

  localparam int NBHD_MOORE       = 0;
  localparam int NBHD_VON_NEUMANN = 1;

  // Von Neumann keeps N, W, E, S (indices 1, 3, 4, 6)
  localparam logic [7:0] NBHD_VN_MASK = 8'b0101_1010;

  // Two-bit two's-complement offsets, entry i at bits [2i+1:2i]
  localparam logic [1:0] OFS_NEG = 2'b11;
  localparam logic [1:0] OFS_ZERO = 2'b00;
  localparam logic [1:0] OFS_POS = 2'b01;
  localparam logic [15:0] NBR_DX_TBL = 16'b01_00_11_01_11_01_00_11;
  localparam logic [15:0] NBR_DY_TBL = 16'b01_01_01_00_00_11_11_11;

  function automatic logic [1:0] nbr_dx(input logic [2:0] idx);
    return NBR_DX_TBL[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] nbr_dy(input logic [2:0] idx);
    return NBR_DY_TBL[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/nbrs_mask_gen.sv
// Combinational relevance masks (current and next cell) and neighbour address arithmetic.
// GOL_NBRS_WRAP_EN selects toroidal wrap instead of excluding edge neighbours.
module nbrs_mask_gen
  import gol_pkg::*;
#(
  parameter int FIELD_W    = 4,
  parameter int FIELD_H    = 3,
  parameter int NBHD_MODE  = 0,
  parameter int X_ADR_SIZE = 2,
  parameter int Y_ADR_SIZE = 2
) (
  input  logic [X_ADR_SIZE-1:0] i_cell_x,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y,
  input  logic [X_ADR_SIZE-1:0] i_nxt_x,
  input  logic [Y_ADR_SIZE-1:0] i_nxt_y,
  input  logic [2:0]            i_idx,
  output logic [7:0]            o_cell_mask,
  output logic [7:0]            o_nxt_mask,
  output logic [X_ADR_SIZE-1:0] o_nbr_x,
  output logic [Y_ADR_SIZE-1:0] o_nbr_y
);

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);
  localparam logic [7:0] MODE_MASK = (NBHD_MODE == NBHD_VON_NEUMANN) ? NBHD_VN_MASK : 8'hFF;

  function automatic logic [7:0] mask_of(input logic [X_ADR_SIZE-1:0] x,
                                         input logic [Y_ADR_SIZE-1:0] y);
    logic [7:0] m;
    logic [1:0] dx;
    logic [1:0] dy;
    logic       off;
    m = MODE_MASK;
`ifdef GOL_NBRS_WRAP_EN
    // Every neighbour exists on a torus; only the mode selects.
    if ((x == X_LAST) && (y == Y_LAST) && 1'b0) m = '0;
`else
    for (int unsigned i = 0; i < NEIGHBOURS_CNT; i++) begin
      dx  = nbr_dx(3'(i));
      dy  = nbr_dy(3'(i));
      off = ((dx == OFS_NEG) && (x == '0)) || ((dx == OFS_POS) && (x == X_LAST)) ||
            ((dy == OFS_NEG) && (y == '0)) || ((dy == OFS_POS) && (y == Y_LAST));
      if (off) m[3'(i)] = 1'b0;
    end
`endif
    return m;
  endfunction

  logic [1:0] dx_sel;
  logic [1:0] dy_sel;

  always_comb begin
    o_cell_mask = mask_of(i_cell_x, i_cell_y);
    o_nxt_mask  = mask_of(i_nxt_x, i_nxt_y);
    dx_sel      = nbr_dx(i_idx);
    dy_sel      = nbr_dy(i_idx);
    o_nbr_x     = i_cell_x;
    o_nbr_y     = i_cell_y;
    case (dx_sel)
      OFS_NEG: o_nbr_x = i_cell_x - X_ADR_SIZE'(1);
      OFS_POS: o_nbr_x = i_cell_x + X_ADR_SIZE'(1);
      default: o_nbr_x = i_cell_x;
    endcase
    case (dy_sel)
      OFS_NEG: o_nbr_y = i_cell_y - Y_ADR_SIZE'(1);
      OFS_POS: o_nbr_y = i_cell_y + Y_ADR_SIZE'(1);
      default: o_nbr_y = i_cell_y;
    endcase
`ifdef GOL_NBRS_WRAP_EN
    // Explicit edge wrap so non-power-of-two fields wrap correctly.
    if ((dx_sel == OFS_NEG) && (i_cell_x == '0))    o_nbr_x = X_LAST;
    if ((dx_sel == OFS_POS) && (i_cell_x == X_LAST)) o_nbr_x = '0;
    if ((dy_sel == OFS_NEG) && (i_cell_y == '0))    o_nbr_y = Y_LAST;
    if ((dy_sel == OFS_POS) && (i_cell_y == Y_LAST)) o_nbr_y = '0;
`endif
  end

endmodule

// File: rtl/nbrs_addr_sequencer.sv
// Raster walk over the field emitting relevant neighbour addresses, one beat per cycle.
// GOL_NBRS_WRAP_EN (in nbrs_mask_gen) selects toroidal wrap.
module nbrs_addr_sequencer
  import gol_pkg::*;
#(
  parameter int FIELD_W   = 4,
  parameter int FIELD_H   = 3,
  parameter int NBHD_MODE = 0,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [X_ADR_SIZE-1:0] o_nbr_x,
  output logic [Y_ADR_SIZE-1:0] o_nbr_y,
  output logic [2:0]            o_nbr_idx,
  output logic [X_ADR_SIZE-1:0] o_cell_x,
  output logic [Y_ADR_SIZE-1:0] o_cell_y,
  output logic                  o_cell_last,
  output logic                  o_field_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [X_ADR_SIZE-1:0]   cell_x_q, cell_x_d;
  logic [Y_ADR_SIZE-1:0]   cell_y_q, cell_y_d;
  nbr_idx_e                idx_q, idx_d;

  logic [X_ADR_SIZE-1:0]   nxt_x;
  logic [Y_ADR_SIZE-1:0]   nxt_y;
  logic [7:0]              cell_mask;
  logic [7:0]              nxt_mask;
  logic [X_ADR_SIZE-1:0]   nbr_x;
  logic [Y_ADR_SIZE-1:0]   nbr_y;
  nbr_idx_e                next_idx;
  nbr_idx_e                first_idx;
  logic                    next_found;
  logic                    first_found;
  logic                    valid;
  logic                    handshake;
  logic                    cell_last;
  logic                    field_last;

  nbrs_mask_gen #(
    .FIELD_W   (FIELD_W),
    .FIELD_H   (FIELD_H),
    .NBHD_MODE (NBHD_MODE),
    .X_ADR_SIZE(X_ADR_SIZE),
    .Y_ADR_SIZE(Y_ADR_SIZE)
  ) u_mask (
    .i_cell_x   (cell_x_q),
    .i_cell_y   (cell_y_q),
    .i_nxt_x    (nxt_x),
    .i_nxt_y    (nxt_y),
    .i_idx      (idx_q),
    .o_cell_mask(cell_mask),
    .o_nxt_mask (nxt_mask),
    .o_nbr_x    (nbr_x),
    .o_nbr_y    (nbr_y)
  );

  // Outside EMIT the "next cell" is (0,0) so a start loads its first index directly.
  always_comb begin
    nxt_x = '0;
    nxt_y = '0;
    if (state_q == ST_EMIT) begin
      if (cell_x_q == X_LAST) begin
        nxt_x = '0;
        nxt_y = cell_y_q + Y_ADR_SIZE'(1);
      end else begin
        nxt_x = cell_x_q + X_ADR_SIZE'(1);
        nxt_y = cell_y_q;
      end
    end
  end

  always_comb begin
    next_found  = 1'b0;
    next_idx    = NBR_NW;
    first_found = 1'b0;
    first_idx   = NBR_NW;
    for (int unsigned i = 0; i < NEIGHBOURS_CNT; i++) begin
      if (!next_found && (i > 32'(idx_q)) && cell_mask[3'(i)]) begin
        next_idx   = nbr_idx_e'(3'(i));
        next_found = 1'b1;
      end
      if (!first_found && nxt_mask[3'(i)]) begin
        first_idx   = nbr_idx_e'(3'(i));
        first_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid      = (state_q == ST_EMIT);
    handshake  = valid && i_ready;
    cell_last  = !next_found;
    field_last = cell_last && (cell_x_q == X_LAST) && (cell_y_q == Y_LAST);

    state_d  = state_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    idx_d    = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (!i_abort && i_start) begin
          state_d  = ST_EMIT;
          cell_x_d = '0;
          cell_y_d = '0;
          idx_d    = first_idx;
        end
      end
      ST_EMIT: begin
        if (i_abort) begin
          state_d  = ST_IDLE;
          cell_x_d = '0;
          cell_y_d = '0;
          idx_d    = NBR_NW;
        end else if (handshake) begin
          if (field_last) begin
            state_d  = ST_DONE;
            cell_x_d = '0;
            cell_y_d = '0;
            idx_d    = NBR_NW;
          end else if (cell_last) begin
            cell_x_d = nxt_x;
            cell_y_d = nxt_y;
            idx_d    = first_idx;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cell_x_q <= '0;
      cell_y_q <= '0;
      idx_q    <= NBR_NW;
    end else begin
      state_q  <= state_d;
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      idx_q    <= idx_d;
    end
  end

  // Beat fields are gated by valid so idle and reset present all-zero outputs.
  always_comb begin
    o_valid      = valid;
    o_nbr_x      = valid ? nbr_x : '0;
    o_nbr_y      = valid ? nbr_y : '0;
    o_nbr_idx    = valid ? idx_q : 3'd0;
    o_cell_x     = valid ? cell_x_q : '0;
    o_cell_y     = valid ? cell_y_q : '0;
    o_cell_last  = valid && cell_last;
    o_field_last = valid && field_last;
    o_busy       = (state_q == ST_EMIT) || (state_q == ST_DONE);
    o_done       = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_nbrs_addr_sequencer.sv
// Self-checking bench: Moore and von Neumann 4x3 sequencers against a beat-list model.
module tb_nbrs_addr_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int MAXB = 96;

  typedef struct packed {
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [2:0]    idx;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          cl;
    logic          fl;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, start, abort, ready;

  logic          v0, v1, busy0, busy1, done0, done1;
  logic [XW-1:0] nx0, nx1, cx0, cx1;
  logic [YW-1:0] ny0, ny1, cy0, cy1;
  logic [2:0]    id0, id1;
  logic          cl0, cl1, fl0, fl1;
  beat_t         ob0, ob1;

  int n_checks = 0;
  int n_err    = 0;

  beat_t exp_tab [2][MAXB];
  int    exp_len [2];
  bit    m_act   [2];
  bit    m_done  [2];
  int    ptr     [2];
  int    beats   [2];
  int    done_cnt[2];
  bit    prev_stall[2];
  beat_t prev_ob [2];
  beat_t last_fl_beat;

  always #5 clk = ~clk;

  nbrs_addr_sequencer #(.FIELD_W(W), .FIELD_H(H), .NBHD_MODE(0)) u_moore (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_ready(ready),
    .o_valid(v0), .o_nbr_x(nx0), .o_nbr_y(ny0), .o_nbr_idx(id0), .o_cell_x(cx0),
    .o_cell_y(cy0), .o_cell_last(cl0), .o_field_last(fl0), .o_busy(busy0), .o_done(done0)
  );

  nbrs_addr_sequencer #(.FIELD_W(W), .FIELD_H(H), .NBHD_MODE(1)) u_vn (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_ready(ready),
    .o_valid(v1), .o_nbr_x(nx1), .o_nbr_y(ny1), .o_nbr_idx(id1), .o_cell_x(cx1),
    .o_cell_y(cy1), .o_cell_last(cl1), .o_field_last(fl1), .o_busy(busy1), .o_done(done1)
  );

  assign ob0 = {nx0, ny0, id0, cx0, cy0, cl0, fl0};
  assign ob1 = {nx1, ny1, id1, cx1, cy1, cl1, fl1};

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Expected beat list from the neighbourhood definition, independent of any sequencing detail.
  task automatic build_model();
    int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int nxv, nyv, n, cell_start;
    bit rel;
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          cell_start = n;
          for (int i = 0; i < 8; i++) begin
            rel = (k == 0) || (i == 1) || (i == 3) || (i == 4) || (i == 6);
            nxv = x + dxs[i];
            nyv = y + dys[i];
`ifdef GOL_NBRS_WRAP_EN
            nxv = (nxv + W) % W;
            nyv = (nyv + H) % H;
`else
            if (nxv < 0 || nxv >= W || nyv < 0 || nyv >= H) rel = 1'b0;
`endif
            if (rel) begin
              b.nx = XW'(nxv); b.ny = YW'(nyv); b.idx = 3'(i);
              b.cx = XW'(x);   b.cy = YW'(y);   b.cl = 1'b0; b.fl = 1'b0;
              exp_tab[k][n] = b;
              n++;
            end
          end
          if (n > cell_start) exp_tab[k][n-1].cl = 1'b1;
        end
      end
      exp_tab[k][n-1].fl = 1'b1;
      exp_len[k] = n;
    end
  endtask

  always @(negedge clk) begin
    logic  ov, obusy, odone;
    beat_t ob;
    for (int k = 0; k < 2; k++) begin
      ov    = (k == 0) ? v0 : v1;
      obusy = (k == 0) ? busy0 : busy1;
      odone = (k == 0) ? done0 : done1;
      ob    = (k == 0) ? ob0 : ob1;
      if (!rst_n) begin
        chk("rst_valid", k, 32'(ov), 32'd0);
        chk("rst_busy", k, 32'(obusy), 32'd0);
        chk("rst_beat", k, 32'(ob), 32'd0);
        m_act[k] = 1'b0; m_done[k] = 1'b0; ptr[k] = 0; prev_stall[k] = 1'b0;
      end else begin
        chk("valid", k, 32'(ov), 32'(m_act[k]));
        chk("busy", k, 32'(obusy), 32'(m_act[k] || m_done[k]));
        chk("done", k, 32'(odone), 32'(m_done[k]));
        if (m_act[k]) chk("beat", k, 32'(ob), 32'(exp_tab[k][ptr[k]]));
        else          chk("idle_beat", k, 32'(ob), 32'd0);
        if (prev_stall[k] && ov) chk("stall_hold", k, 32'(ob), 32'(prev_ob[k]));
        if (odone) done_cnt[k]++;
        if (k == 0 && ov && ready && ob.fl) last_fl_beat = ob;
        prev_stall[k] = ov && !ready && !abort;
        prev_ob[k]    = ob;
        if (abort) begin
          m_act[k] = 1'b0; m_done[k] = 1'b0; ptr[k] = 0;
        end else if (m_done[k]) begin
          m_done[k] = 1'b0;
        end else if (m_act[k]) begin
          if (ready) begin
            ptr[k]++; beats[k]++;
            if (ptr[k] == exp_len[k]) begin
              m_act[k] = 1'b0; m_done[k] = 1'b1; ptr[k] = 0;
            end
          end
        end else if (start) begin
          m_act[k] = 1'b1; ptr[k] = 0; beats[k] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready, input bit poke_start);
    int c = 0;
    while ((m_act[0] || m_done[0] || m_act[1] || m_done[1]) && c < budget) begin
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      start = poke_start && m_act[0] && ($urandom_range(0, 15) == 0);
      step();
      c++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("walk_timeout", 0, 32'(c < budget), 32'd1);
  endtask

  initial begin
    int d0, d1, vn_base, c;
    build_model();
    // Pin the model against hand-derived figures.
`ifdef GOL_NBRS_WRAP_EN
    chk("model_len_moore", 0, 32'(exp_len[0]), 32'd96);
    chk("model_len_vn", 1, 32'(exp_len[1]), 32'd48);
    chk("model_c00_i0", 0, 32'(exp_tab[0][0]), 32'({2'd3, 2'd2, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0}));
    vn_base = 20;
`else
    chk("model_len_moore", 0, 32'(exp_len[0]), 32'd58);
    chk("model_len_vn", 1, 32'(exp_len[1]), 32'd34);
    chk("model_c00_a", 0, 32'(exp_tab[0][0].idx), 32'd4);
    chk("model_c00_b", 0, 32'(exp_tab[0][1].idx), 32'd6);
    chk("model_c00_c", 0, 32'({exp_tab[0][2].idx, exp_tab[0][2].cl}), 32'({3'd7, 1'b1}));
    vn_base = 13;
`endif
    chk("model_vn11_0", 1, 32'(exp_tab[1][vn_base+0]), 32'({2'd1, 2'd0, 3'd1, 2'd1, 2'd1, 1'b0, 1'b0}));
    chk("model_vn11_1", 1, 32'(exp_tab[1][vn_base+1]), 32'({2'd0, 2'd1, 3'd3, 2'd1, 2'd1, 1'b0, 1'b0}));
    chk("model_vn11_2", 1, 32'(exp_tab[1][vn_base+2]), 32'({2'd2, 2'd1, 3'd4, 2'd1, 2'd1, 1'b0, 1'b0}));
    chk("model_vn11_3", 1, 32'(exp_tab[1][vn_base+3]), 32'({2'd1, 2'd2, 3'd6, 2'd1, 2'd1, 1'b1, 1'b0}));

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_done[k] = 0; ptr[k] = 0; beats[k] = 0; done_cnt[k] = 0;
    end
    step(); step();
    chk("reset_out", 0, 32'({v0, busy0, done0, ob0}), 32'd0);
    rst_n = 1'b1;
    step();

    // Walk 1: ready tied high.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    pulse_start();
    wait_idle(400, 1'b0, 1'b0);
    chk("beats_moore", 0, 32'(beats[0]), 32'(exp_len[0]));
    chk("beats_vn", 1, 32'(beats[1]), 32'(exp_len[1]));
    chk("done_once_moore", 0, 32'(done_cnt[0] - d0), 32'd1);
    chk("done_once_vn", 1, 32'(done_cnt[1] - d1), 32'd1);
`ifdef GOL_NBRS_WRAP_EN
    chk("field_last_pos", 0, 32'({last_fl_beat.cx, last_fl_beat.cy, last_fl_beat.idx}), 32'({2'd3, 2'd2, 3'd7}));
`else
    chk("field_last_pos", 0, 32'({last_fl_beat.cx, last_fl_beat.cy, last_fl_beat.idx}), 32'({2'd3, 2'd2, 3'd3}));
`endif

    // Walk 2: random backpressure with stray starts during EMIT.
    d0 = done_cnt[0];
    pulse_start();
    wait_idle(2000, 1'b1, 1'b1);
    chk("beats_bp", 0, 32'(beats[0]), 32'(exp_len[0]));
    chk("done_once_bp", 0, 32'(done_cnt[0] - d0), 32'd1);

    // Abort at beat 10.
    d0 = done_cnt[0];
    pulse_start();
    c = 0;
    while (beats[0] != 10 && c < 100) begin step(); c++; end
    chk("reach_beat10", 0, 32'(beats[0]), 32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 0, 32'(v0), 32'd0);
    repeat (4) step();
    chk("abort_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);

    // Restart after abort begins at (0,0).
    pulse_start();
    chk("restart_cell", 0, 32'({v0, cx0, cy0}), 32'({1'b1, 2'd0, 2'd0}));
    wait_idle(400, 1'b0, 1'b0);
    chk("restart_beats", 0, 32'(beats[0]), 32'(exp_len[0]));

    // Start and abort together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    chk("start_abort_idle", 0, 32'({busy0, v0, busy1, v1}), 32'd0);

    // Asynchronous reset mid-walk.
    d0 = done_cnt[0];
    pulse_start();
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_moore", 0, 32'({v0, busy0, done0, ob0}), 32'd0);
    chk("rst_mid_vn", 1, 32'({v1, busy1, done1, ob1}), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);
    pulse_start();
    chk("post_rst_cell", 0, 32'({v0, cx0, cy0}), 32'({1'b1, 2'd0, 2'd0}));
    wait_idle(400, 1'b0, 1'b0);
    chk("post_rst_beats", 0, 32'(beats[0]), 32'(exp_len[0]));

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
